alu_logic_pipe: RTL
===================

Name: alu_logic_pipe

Overview:
- Two-stage registered wrapper around the 32-bit logic units (bitwise AND, bitwise OR, single-bit select `x & (1<<y[4:0])`).
- Accepts operand/opcode requests over a valid/ready handshake and registers operands in stage 1.
- Computes the selected function and registers the result in stage 2.
- Presents the result with valid/ready, zero and error flags, and a retired-operation counter.
- Sits between the instruction-decode/issue logic (upstream) and the combinational logic units.

Parameters:
- CNT_W, 16, width of retired-operation counter `retire_cnt`.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  stage can accept request this cycle.
- op  in  2  00 = AND, 01 = OR, 10 = BITSEL, 11 = reserved.
- x  in  32  operand A.
- y  in  32  operand B; BITSEL uses `y[4:0]` only.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- f  out  32  result.
- zero  out  1  f == 0, qualified by out_valid.
- op_err  out  1  result came from reserved opcode.
- retire_cnt  out  CNT_W  count of results handed off (out_valid & out_ready).

Behaviour:
- Reset is asynchronous and active-low, on `rst_n`, in the single `clk` domain.
- While `rst_n` = 0, all of the following are held at 0:
  - s1_valid, s2_valid, out_valid, f, zero, op_err, retire_cnt.
- While `rst_n` = 0, in_ready = 0.
- After reset release, in_ready = 1 from the first cycle.
- Stage 1 (s1) holds registers op_q, x_q, y_q and s1_valid.
- Stage 2 (s2) drives f, zero, op_err and out_valid = s2_valid.
- Handshake and advance rules:
  - `s2_free` = !s2_valid | out_ready.
  - `s1_adv` = s1_valid & s2_free.
  - in_ready = !s1_valid | s2_free. It is a combinational path from out_ready; this is allowed and documented.
  - accept = in_valid & in_ready. On accept, s1 loads op/x/y and s1_valid <= 1. Otherwise, if s1_adv, s1_valid <= 0.
  - If s2_free: s2 loads the function of s1 and s2_valid <= s1_valid. Otherwise s2 holds.
- Stalled result behaviour:
  - While out_valid & !out_ready, f, zero and op_err are stable.
  - s1 keeps its entry; in_ready = 0 if s1 is occupied.
- Function rules:
  - AND: f = x_q & y_q.
  - OR: f = x_q | y_q.
  - BITSEL: f = x_q & (32'h1 << y_q[4:0]), so at most one bit is set. `y_q[31:5]` is ignored.
  - Reserved (11): f = 0, op_err = 1.
  - zero = (f == 0), including the reserved case (zero = 1 there).
- Latency: a request accepted at edge T gives out_valid = 1 after edge T+1, provided no stall.
- Throughput: one operation per cycle when out_ready is held high.
- Empty pipe: a bubble in s1 propagates as s2_valid <= 0 when s2_free. f and the flags keep their last values but are don't-care while out_valid = 0.
- Simultaneous events:
  - accept and s1_adv in the same cycle: s1 reloads, s2 takes the old s1 contents, no loss.
  - out_ready with s2 full and s1 empty: s2_valid <= 0.
- retire_cnt:
  - Increments by 1 on each out_valid & out_ready.
  - Wraps modulo 2^CNT_W with no saturation and no flag.
- Reset mid-operation: all in-flight entries are discarded immediately (asynchronously); no result is emitted for them.
- Ordering: results are strictly in acceptance order; no reordering, no drops, no duplicates.

Test Plan:
- Reset then single AND, out_ready = 1:
  - Stimulus: x = 32'hF0F0_1234, y = 32'h0FF0_FFFF, op = 00, accepted at edge T.
  - Required: out_valid high after T+1, f = 32'h00F0_1234, zero = 0, op_err = 0, retire_cnt = 1.
- BITSEL boundaries:
  - x = 32'h8000_0001, y = 31 → f = 32'h8000_0000.
  - Same x, y = 32'hFFFF_FFE0 (y[4:0] = 0) → f = 32'h0000_0001.
  - Same x, y = 5 → f = 0 and zero = 1.
- Back-to-back stream, out_ready = 1:
  - Stimulus: 8 ORs x = i, y = i<<8 for i = 0..7.
  - Required: in_ready constantly 1; results i|(i<<8) emitted on 8 consecutive cycles, in order; retire_cnt = 8.
- Backpressure:
  - Stimulus: issue 3 ops with out_ready = 0.
  - Required: s1 and s2 fill; in_ready drops after 2 accepts; f stable while stalled; no loss. Raising out_ready delivers all 3 in order.
- Reserved op:
  - Stimulus: op = 11, x = y = 32'hFFFF_FFFF.
  - Required: f = 0, op_err = 1, zero = 1, and it counts in retire_cnt.
- Reset mid-stall and counter wrap:
  - Assert rst_n = 0 with s2 full → out_valid = 0 immediately and retire_cnt = 0.
  - With CNT_W = 4, 17 retirements → retire_cnt = 1.

Source files
------------

// File: rtl/alu_logic_pipe.sv
// Two-stage registered wrapper around the 32-bit AND / OR / bit-select logic units,
// with valid/ready handshake on both sides and a retired-operation counter.
module alu_logic_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [31:0]      x,
  input  logic [31:0]      y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      f,
  output logic             zero,
  output logic             op_err,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam logic [1:0] OP_AND    = 2'b00;
  localparam logic [1:0] OP_OR     = 2'b01;
  localparam logic [1:0] OP_BITSEL = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  function automatic logic [31:0] logic_fn(input logic [1:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    case (o)
      OP_AND:    r = a & b;
      OP_OR:     r = a | b;
      OP_BITSEL: r = a & (32'h0000_0001 << b[4:0]);
      default:   r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  logic             s1_valid_r;
  logic [1:0]       op_r;
  logic [31:0]      x_r;
  logic [31:0]      y_r;
  logic             s2_valid_r;
  logic [31:0]      f_r;
  logic             zero_r;
  logic             op_err_r;
  logic [CNT_W-1:0] retire_cnt_r;

  logic        s2_free_s;
  logic        s1_adv_s;
  logic        accept_s;
  logic [31:0] fn_s;

  // Handshake decode; in_ready is a deliberate combinational path from out_ready.
  always_comb begin
    s2_free_s = 1'b0;
    s1_adv_s  = 1'b0;
    in_ready  = 1'b0;
    accept_s  = 1'b0;
    fn_s      = logic_fn(op_r, x_r, y_r);
    if (rst_n) begin
      s2_free_s = !s2_valid_r || out_ready;
      s1_adv_s  = s1_valid_r && s2_free_s;
      in_ready  = !s1_valid_r || s2_free_s;
      accept_s  = in_valid && in_ready;
    end else begin
      s2_free_s = 1'b0;
    end
  end

  // Stage 1: operand/opcode capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      op_r       <= 2'b00;
      x_r        <= 32'h0000_0000;
      y_r        <= 32'h0000_0000;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      op_r       <= op;
      x_r        <= x;
      y_r        <= y;
    end else if (s1_adv_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Stage 2: result register; bubbles move valid only so f and flags keep their last values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      f_r        <= 32'h0000_0000;
      zero_r     <= 1'b0;
      op_err_r   <= 1'b0;
    end else if (s2_free_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        f_r      <= fn_s;
        zero_r   <= (fn_s == 32'h0000_0000);
        op_err_r <= (op_r == OP_RSVD);
      end
    end
  end

  // Retired-operation counter, wraps freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt_r <= {CNT_W{1'b0}};
    end else if (s2_valid_r && out_ready) begin
      retire_cnt_r <= retire_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_valid  = s2_valid_r;
  assign f          = f_r;
  assign zero       = zero_r;
  assign op_err     = op_err_r;
  assign retire_cnt = retire_cnt_r;

endmodule
